// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core.
// Holds opcode/funct encodings, the control FSM state type, the PC source
// select, 3-bit ALU control codes and the ALU evaluation/decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_TARGET = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_t;

  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic logic [2:0] funct_alu_ctl(input logic [5:0] funct);
    logic [2:0] ctl;
    case (funct)
      FN_SUB:  ctl = ALU_SUB;
      FN_AND:  ctl = ALU_AND;
      FN_OR:   ctl = ALU_OR;
      FN_SLT:  ctl = ALU_SLT;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Two's complement, overflow wraps silently; slt compares signed.
  function automatic logic [31:0] alu_eval(input logic [2:0] ctl,
                                           input logic signed [31:0] x,
                                           input logic signed [31:0] y);
    logic [31:0] r;
    case (ctl)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = {31'd0, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Control FSM of the multicycle MIPS core.
// Inputs : clk, clr_n (async active-low), op/funct of IR, ALU zero flag,
//          mem_ready handshake.
// Outputs: state-decoded register enables, mux selects, memory request
//          strobes, and registered retire/halted/illegal status.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic       ab_we,
  output logic       alu_we,
  output logic       mdr_we,
  output logic       rf_we,
  output pc_src_t    pc_src,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] alu_ctl,
  output logic       rf_dst_rd,
  output logic       rf_src_mdr,
  output logic       mem_req,
  output logic       mem_we,
  output logic       data_addr,
  output logic       retire,
  output logic       halted,
  output logic       illegal
);

  state_t state, state_next;
  logic   done;

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_supported(funct) ? S_EXEC : S_HALT;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      default:  state_next = S_HALT;
    endcase
  end

  assign done = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
                (state == S_BRANCH) || (state == S_JUMP) ||
                ((state == S_MEMWR) && mem_ready);

  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    ab_we      = 1'b0;
    alu_we     = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    pc_src     = PC_INC;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_ctl    = ALU_ADD;
    rf_dst_rd  = 1'b0;
    rf_src_mdr = 1'b0;
    case (state)
      S_FETCH: begin
        ir_we = mem_ready;
        pc_we = mem_ready;
      end
      // ALU computes PC(+1) + sext(imm) as the speculative branch target.
      S_DECODE: begin
        ab_we     = 1'b1;
        alu_we    = 1'b1;
        alu_src_b = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_we    = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 1'b1;
      end
      S_MEMRD:  mdr_we = mem_ready;
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_src_mdr = 1'b1;
      end
      S_EXEC: begin
        alu_we    = 1'b1;
        alu_src_a = 1'b1;
        alu_ctl   = funct_alu_ctl(funct);
      end
      S_ALUWB: begin
        rf_we     = 1'b1;
        rf_dst_rd = 1'b1;
      end
      S_ADDIWB: rf_we = 1'b1;
      // ALUOut keeps the target; the ALU is free to compare A and B.
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_we     = zero;
        pc_src    = PC_TARGET;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
      end
      default: ;
    endcase
  end

  // Gated by clr_n so an outstanding request is withdrawn the moment reset
  // is asserted, not at the next edge.
  assign mem_req   = clr_n && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
  assign mem_we    = (state == S_MEMWR);
  assign data_addr = (state == S_MEMRD) || (state == S_MEMWR);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_FETCH;
      retire  <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      retire  <= done;
      halted  <= (state_next == S_HALT);
      illegal <= illegal || ((state == S_DECODE) && (state_next == S_HALT));
    end
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core datapath with a single shared word-addressed memory
// port using a req/ready handshake.
// Params : AW (word-address width), RESET_PC.
// Ports  : clk, clr_n (async active-low); mem_req/mem_we/mem_addr/mem_wdata
//          out, mem_rdata/mem_ready in; pc, retire, halted, illegal status.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter int              AW       = 6,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          clr_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] pc,
  output logic          retire,
  output logic          halted,
  output logic          illegal
);

  logic [31:0]        ir, mdr, alu_out;
  logic signed [31:0] a, b;
  logic [31:0]        rf [32];

  logic        ir_we, pc_we, ab_we, alu_we, mdr_we, rf_we;
  pc_src_t     pc_src;
  logic        alu_src_a, alu_src_b, rf_dst_rd, rf_src_mdr, data_addr;
  logic [2:0]  alu_ctl;

  logic signed [31:0] imm_sext, src_a, src_b;
  logic [31:0]        alu_res, rf_wd;
  logic [4:0]         rf_wa;
  logic [AW-1:0]      pc_next;
  logic               zero;

  mips_mc_control u_control (
    .clk       (clk),
    .clr_n     (clr_n),
    .op        (ir[31:26]),
    .funct     (ir[5:0]),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .ab_we     (ab_we),
    .alu_we    (alu_we),
    .mdr_we    (mdr_we),
    .rf_we     (rf_we),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_ctl   (alu_ctl),
    .rf_dst_rd (rf_dst_rd),
    .rf_src_mdr(rf_src_mdr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .data_addr (data_addr),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal)
  );

  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign src_a    = alu_src_a ? a : 32'(pc);
  assign src_b    = alu_src_b ? imm_sext : b;
  assign alu_res  = alu_eval(alu_ctl, src_a, src_b);
  assign zero     = (alu_res == 32'd0);

  assign rf_wa = rf_dst_rd ? ir[15:11] : ir[20:16];
  assign rf_wd = rf_src_mdr ? mdr : alu_out;

  // Addresses and targets are truncated to AW bits, so PC math wraps.
  always_comb begin
    case (pc_src)
      PC_TARGET: pc_next = alu_out[AW-1:0];
      PC_JUMP:   pc_next = ir[AW-1:0];
      default:   pc_next = pc + AW'(1);
    endcase
  end

  assign mem_addr  = data_addr ? alu_out[AW-1:0] : pc;
  assign mem_wdata = b;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (pc_we)  pc      <= pc_next;
      if (ir_we)  ir      <= mem_rdata;
      if (mdr_we) mdr     <= mem_rdata;
      if (ab_we) begin
        a <= rf[ir[25:21]];
        b <= rf[ir[20:16]];
      end
      if (alu_we) alu_out <= alu_res;
    end
  end

  // Register $0 is never written, so it always reads as zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      rf[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed self-checking bench for mips_multicycle (AW=6, RESET_PC=0).
// A 64-word memory model answers the shared port; programs are hand-encoded.
module tb_mips_multicycle;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100010, T_AND = 6'b100100;
  localparam logic [5:0] T_OR = 6'b100101, T_SLT = 6'b101010;
  localparam logic [31:0] T_BAD = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        mem_req, mem_we, ready;
  logic [5:0]  mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata;
  logic        retire, halted, illegal;
  logic [31:0] mem [64];
  int          tests = 0, fails = 0, retire_cnt = 0;

  always #5 clk = ~clk;

  // Data is only valid when the request is accepted; otherwise garbage.
  assign mem_rdata = (mem_req && ready) ? mem[mem_addr] : 32'hBAD0_BAD0;

  mips_multicycle #(.AW(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .clr_n(clr_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(ready), .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the port just before the edge, commit a write on it.
  task automatic tick();
    logic        wr;
    logic [5:0]  wa;
    logic [31:0] wd;
    #1;
    wr = mem_req && mem_we && ready;
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
    if (retire) retire_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic hold_reset();
    clr_n = 1'b0;
    ready = 1'b1;
    ticks(2);
  endtask

  task automatic release_reset();
    clr_n = 1'b1;
    retire_cnt = 0;
    #1;
  endtask

  task automatic run_until_halted(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    check("halt_reached", halted, 1);
  endtask

  initial begin
    ready = 1'b1;

    // Program 1: addi/addi/add/sw with no wait states.
    clear_mem();
    mem[0] = enc_i(T_ADDI, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(T_ADDI, 5'd0, 5'd2, 16'd7);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, T_ADD);
    mem[3] = enc_i(T_SW, 5'd0, 5'd3, 16'd10);
    mem[4] = T_BAD;
    hold_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pc", pc, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    release_reset();
    check("first_fetch_req", mem_req, 1);
    check("first_fetch_addr", mem_addr, 0);
    ticks(15);
    check("p1_retires_15", retire_cnt, 3);
    check("p1_sw_req", mem_req, 1);
    check("p1_sw_we", mem_we, 1);
    check("p1_sw_addr", mem_addr, 10);
    tick();
    check("p1_retires_16", retire_cnt, 4);
    check("p1_mem10", mem[10], 32'd12);
    check("p1_pc", pc, 4);

    // Program 2: sub/slt/and/or on negative operands, write to $0, illegal op.
    clear_mem();
    mem[0]  = enc_i(T_ADDI, 5'd0, 5'd1, 16'hFFFD);
    mem[1]  = enc_i(T_ADDI, 5'd0, 5'd2, 16'd4);
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, T_SUB);
    mem[3]  = enc_r(5'd1, 5'd2, 5'd4, T_SLT);
    mem[4]  = enc_r(5'd2, 5'd1, 5'd7, T_SLT);
    mem[5]  = enc_r(5'd1, 5'd2, 5'd5, T_AND);
    mem[6]  = enc_r(5'd1, 5'd2, 5'd6, T_OR);
    mem[7]  = enc_i(T_ADDI, 5'd0, 5'd0, 16'd9);
    mem[8]  = enc_i(T_SW, 5'd0, 5'd3, 16'd20);
    mem[9]  = enc_i(T_SW, 5'd0, 5'd4, 16'd21);
    mem[10] = enc_i(T_SW, 5'd0, 5'd7, 16'd25);
    mem[11] = enc_i(T_SW, 5'd0, 5'd5, 16'd23);
    mem[12] = enc_i(T_SW, 5'd0, 5'd6, 16'd24);
    mem[13] = enc_i(T_SW, 5'd0, 5'd0, 16'd22);
    mem[14] = T_BAD;
    hold_reset();
    release_reset();
    run_until_halted(200);
    check("p2_sub", mem[20], 32'hFFFF_FFF9);
    check("p2_slt_lt", mem[21], 32'd1);
    check("p2_slt_ge", mem[25], 32'd0);
    check("p2_and", mem[23], 32'd4);
    check("p2_or", mem[24], 32'hFFFF_FFFD);
    check("p2_r0_zero", mem[22], 32'd0);
    check("p2_retires", retire_cnt, 14);
    check("p2_illegal", illegal, 1);
    check("p2_pc_halt", pc, 15);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p2_halt_no_req", mem_req, 0);
    end
    check("p2_pc_frozen", pc, 15);
    check("p2_still_halted", halted, 1);

    // Program 3: lw with three wait states in MEMRD.
    clear_mem();
    mem[0]  = enc_i(T_LW, 5'd0, 5'd5, 16'd30);
    mem[1]  = enc_i(T_SW, 5'd0, 5'd5, 16'd31);
    mem[2]  = T_BAD;
    mem[30] = 32'h1234_5678;
    hold_reset();
    release_reset();
    ticks(3);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_req", mem_req, 1);
      check("lw_wait_addr", mem_addr, 30);
      check("lw_wait_we", mem_we, 0);
      tick();
    end
    check("lw_wait_req_end", mem_req, 1);
    check("lw_wait_addr_end", mem_addr, 30);
    ready = 1'b1;
    tick();
    check("lw_no_retire_7", retire, 0);
    tick();
    check("lw_retire_8", retire, 1);
    check("lw_pc", pc, 1);
    run_until_halted(50);
    check("lw_value", mem[31], 32'h1234_5678);
    check("lw_retires", retire_cnt, 2);

    // Program 4: beq at PC 63 wraps; taken then not-taken.
    clear_mem();
    mem[0]  = enc_j(26'd63);
    mem[63] = enc_i(T_BEQ, 5'd1, 5'd0, 16'd1);
    mem[1]  = enc_i(T_ADDI, 5'd0, 5'd1, 16'd1);
    mem[2]  = enc_j(26'd63);
    hold_reset();
    release_reset();
    ticks(3);
    check("j_pc", pc, 63);
    ticks(3);
    check("beq_taken_wrap", pc, 1);
    ticks(4);
    check("addi_pc", pc, 2);
    ticks(3);
    check("j2_pc", pc, 63);
    ticks(3);
    check("beq_not_taken_wrap", pc, 0);
    check("beq_retires", retire_cnt, 5);

    // Program 5: reset during a stalled store.
    clear_mem();
    mem[0]  = enc_i(T_ADDI, 5'd0, 5'd1, 16'h0055);
    mem[1]  = enc_i(T_SW, 5'd0, 5'd1, 16'd40);
    mem[40] = 32'hCAFE_F00D;
    hold_reset();
    release_reset();
    ticks(7);
    ready = 1'b0;
    tick();
    check("sw_pend_req", mem_req, 1);
    check("sw_pend_we", mem_we, 1);
    check("sw_pend_addr", mem_addr, 40);
    check("sw_pend_wdata", mem_wdata, 32'h55);
    clr_n = 1'b0;
    #1;
    check("abort_req_drop", mem_req, 0);
    check("abort_we", mem_we, 0);
    check("abort_pc", pc, 0);
    ready = 1'b1;
    ticks(2);
    check("abort_mem_kept", mem[40], 32'hCAFE_F00D);
    release_reset();
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 0);
    ticks(8);
    check("restart_retires", retire_cnt, 2);
    check("restart_store", mem[40], 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
